// File: rtl/execute_stage_pkg.sv
// Shared definitions for the RV64I execute stage: widths, ALU opcode enum,
// control-bit indices, access-width one-hots and the two pipeline-register bundles.
package execute_stage_pkg;

    localparam int XLEN   = 64;
    localparam int RID_W  = 5;
    localparam int INST_W = 32;
    localparam int SIG_W  = 11;
    localparam int WDT_W  = 4;

    // Bit positions inside the sig_op control vector
    localparam int SIG_REG_WEN      = 0;
    localparam int SIG_IS_LOAD      = 1;
    localparam int SIG_MEM_WEN      = 2;
    localparam int SIG_IS_BRANCH    = 3;
    localparam int SIG_IS_JAL       = 4;
    localparam int SIG_IS_JALR      = 5;
    localparam int SIG_IS_AUIPC     = 6;
    localparam int SIG_NEED_IMM     = 7;
    localparam int SIG_IS_UNSIGNED  = 8;
    localparam int SIG_IS_EBREAK    = 9;
    localparam int SIG_INST_NOT_IPL = 10;

    // Access width one-hot {D,W,H,B}
    localparam logic [WDT_W-1:0] WDT_B = 4'b0001;
    localparam logic [WDT_W-1:0] WDT_H = 4'b0010;
    localparam logic [WDT_W-1:0] WDT_W_ = 4'b0100;
    localparam logic [WDT_W-1:0] WDT_D = 4'b1000;

    typedef enum logic [4:0] {
        ALU_NONE = 5'd0,
        ALU_ADD  = 5'd1,
        ALU_SUB  = 5'd2,
        ALU_AND  = 5'd3,
        ALU_OR   = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SLL  = 5'd6,
        ALU_SRL  = 5'd7,
        ALU_SRA  = 5'd8,
        ALU_SLT  = 5'd9,
        ALU_SLTU = 5'd10,
        ALU_BEQ  = 5'd11,
        ALU_BNE  = 5'd12,
        ALU_BLT  = 5'd13,
        ALU_BGE  = 5'd14,
        ALU_BLTU = 5'd15,
        ALU_BGEU = 5'd16,
        ALU_LUI  = 5'd17,
        ALU_ADDW = 5'd18,
        ALU_SUBW = 5'd19,
        ALU_SLLW = 5'd20,
        ALU_SRLW = 5'd21,
        ALU_SRAW = 5'd22
    } alu_op_e;

    typedef struct packed {
        alu_op_e             alu_op;
        logic [WDT_W-1:0]    wdt_op;
        logic [SIG_W-1:0]    sig_op;
        logic [XLEN-1:0]     imm;
        logic [XLEN-1:0]     rdata1;
        logic [XLEN-1:0]     rdata2;
        logic [XLEN-1:0]     pc;
        logic [INST_W-1:0]   inst;
        logic [RID_W-1:0]    rd;
        logic                flush;
        logic                fwd1;
        logic                fwd2;
    } id_ex_t;

    typedef struct packed {
        logic                flush;
        logic [RID_W-1:0]    rd;
        logic [SIG_W-1:0]    sig_op;
        logic [WDT_W-1:0]    wdt_op;
        logic [XLEN-1:0]     alu_result;
        logic [XLEN-1:0]     rdata2;
        logic [XLEN-1:0]     imm;
        logic [XLEN-1:0]     pc;
        logic [INST_W-1:0]   inst;
    } ex_mem_t;

    // Zero-extend a single comparison outcome to a full datapath word
    function automatic logic [XLEN-1:0] to_flag(input logic b);
        return {{(XLEN-1){1'b0}}, b};
    endfunction

endpackage

// File: rtl/execute_alu.sv
// Combinational RV64I ALU. Branch opcodes return 1 when taken, 0 otherwise.
// Optional feature macro: EXECUTE_STAGE_WORD_OPS_EN adds the 32-bit W-suffix ops.
module execute_alu
    import execute_stage_pkg::*;
(
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  alu_op_e         alu_op_i,
    output logic [XLEN-1:0] result_o
);

`ifdef EXECUTE_STAGE_WORD_OPS_EN
    // Sign-extend a 32-bit word result to the full datapath width
    function automatic logic [XLEN-1:0] sext_w(input logic [31:0] w);
        return {{(XLEN-32){w[31]}}, w};
    endfunction
`endif

    logic [5:0] shamt;
    assign shamt = op2_i[5:0];

    // Select the operation result; unknown opcodes produce zero
    always_comb begin
        // NOTE: default assignment first so every path drives result_o and no latch is inferred.
        result_o = '0;
        case (alu_op_i)
            ALU_ADD:  result_o = op1_i + op2_i;
            ALU_SUB:  result_o = op1_i - op2_i;
            ALU_AND:  result_o = op1_i & op2_i;
            ALU_OR:   result_o = op1_i | op2_i;
            ALU_XOR:  result_o = op1_i ^ op2_i;
            ALU_SLL:  result_o = op1_i << shamt;
            ALU_SRL:  result_o = op1_i >> shamt;
            ALU_SRA:  result_o = $unsigned($signed(op1_i) >>> shamt);
            ALU_SLT:  result_o = to_flag($signed(op1_i) < $signed(op2_i));
            ALU_SLTU: result_o = to_flag(op1_i < op2_i);
            ALU_BEQ:  result_o = to_flag(op1_i == op2_i);
            ALU_BNE:  result_o = to_flag(op1_i != op2_i);
            ALU_BLT:  result_o = to_flag($signed(op1_i) < $signed(op2_i));
            ALU_BGE:  result_o = to_flag($signed(op1_i) >= $signed(op2_i));
            ALU_BLTU: result_o = to_flag(op1_i < op2_i);
            ALU_BGEU: result_o = to_flag(op1_i >= op2_i);
            ALU_LUI:  result_o = op2_i;
`ifdef EXECUTE_STAGE_WORD_OPS_EN
            ALU_ADDW: result_o = sext_w(op1_i[31:0] + op2_i[31:0]);
            ALU_SUBW: result_o = sext_w(op1_i[31:0] - op2_i[31:0]);
            ALU_SLLW: result_o = sext_w(op1_i[31:0] << op2_i[4:0]);
            ALU_SRLW: result_o = sext_w(op1_i[31:0] >> op2_i[4:0]);
            ALU_SRAW: result_o = sext_w($unsigned($signed(op1_i[31:0]) >>> op2_i[4:0]));
`endif
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage of the 5-stage RV64I pipeline: ID/EX register, operand select
// with load-use bypass from MEM, ALU, flush generation and the EX/MEM register.
// Optional feature macro: EXECUTE_STAGE_WORD_OPS_EN (enables W-suffix ALU ops).
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        alu_op_id,
    input  logic [WDT_W-1:0]  wdt_op_id,
    input  logic [SIG_W-1:0]  sig_op_id,
    input  logic [XLEN-1:0]   imm_id,
    input  logic [XLEN-1:0]   pc_id,
    input  logic [XLEN-1:0]   rdata1_id,
    input  logic [XLEN-1:0]   rdata2_id,
    input  logic [INST_W-1:0] inst_id,
    input  logic [RID_W-1:0]  rd_id,
    input  logic              flush_id,
    input  logic              fwd1_id,
    input  logic              fwd2_id,
    input  logic [XLEN-1:0]   load_data_mem,
    output logic [XLEN-1:0]   alu_result_ex,
    output logic [RID_W-1:0]  rd_ex,
    output logic [SIG_W-1:0]  sig_op_ex,
    output logic              flush_ex,
    output logic              flush_mem,
    output logic [RID_W-1:0]  rd_mem,
    output logic [SIG_W-1:0]  sig_op_mem,
    output logic [WDT_W-1:0]  wdt_op_mem,
    output logic [XLEN-1:0]   alu_result_mem,
    output logic [XLEN-1:0]   rdata2_mem,
    output logic [XLEN-1:0]   imm_mem,
    output logic [XLEN-1:0]   pc_mem,
    output logic [INST_W-1:0] inst_mem
);

    id_ex_t          id_ex_d, id_ex_q;
    ex_mem_t         ex_mem_d, ex_mem_q;
    logic [XLEN-1:0] op1, op2, rdata2_byp;
    logic            load_in_mem;

    // Bundle the ID-stage inputs as the ID/EX next state
    always_comb begin
        id_ex_d.alu_op = alu_op_e'(alu_op_id);
        id_ex_d.wdt_op = wdt_op_id;
        id_ex_d.sig_op = sig_op_id;
        id_ex_d.imm    = imm_id;
        id_ex_d.rdata1 = rdata1_id;
        id_ex_d.rdata2 = rdata2_id;
        id_ex_d.pc     = pc_id;
        id_ex_d.inst   = inst_id;
        id_ex_d.rd     = rd_id;
        id_ex_d.flush  = flush_id;
        id_ex_d.fwd1   = fwd1_id;
        id_ex_d.fwd2   = fwd2_id;
    end

    // ID/EX register: reset or an EX flush inserts an all-zero bubble
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
        if (rst || flush_ex) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign load_in_mem = ex_mem_q.sig_op[SIG_IS_LOAD];

    // Operand select: pc for auipc/jal, immediate when needed, load data bypass from MEM
    always_comb begin
        op1 = id_ex_q.rdata1;
        op2 = id_ex_q.rdata2;
        rdata2_byp = id_ex_q.rdata2;
        if (id_ex_q.fwd2 && load_in_mem) begin
            rdata2_byp = load_data_mem;
        end
        if (id_ex_q.sig_op[SIG_IS_AUIPC] || id_ex_q.sig_op[SIG_IS_JAL]) begin
            op1 = id_ex_q.pc;
        end else if (id_ex_q.fwd1 && load_in_mem) begin
            op1 = load_data_mem;
        end
        if (id_ex_q.sig_op[SIG_NEED_IMM]) begin
            op2 = id_ex_q.imm;
        end else begin
            op2 = rdata2_byp;
        end
    end

    execute_alu u_alu (
        .op1_i    (op1),
        .op2_i    (op2),
        .alu_op_i (id_ex_q.alu_op),
        .result_o (alu_result_ex)
    );

    // A registered jal/jalr flush or a taken branch squashes the instruction in ID
    assign flush_ex = id_ex_q.flush
                    | (id_ex_q.sig_op[SIG_IS_BRANCH] & (alu_result_ex == XLEN'(1)));

    assign rd_ex     = id_ex_q.rd;
    assign sig_op_ex = id_ex_q.sig_op;

    // Bundle the EX results as the EX/MEM next state
    always_comb begin
        ex_mem_d.flush      = flush_ex;
        ex_mem_d.rd         = id_ex_q.rd;
        ex_mem_d.sig_op     = id_ex_q.sig_op;
        ex_mem_d.wdt_op     = id_ex_q.wdt_op;
        ex_mem_d.alu_result = alu_result_ex;
        ex_mem_d.rdata2     = rdata2_byp;
        ex_mem_d.imm        = id_ex_q.imm;
        ex_mem_d.pc         = id_ex_q.pc;
        ex_mem_d.inst       = id_ex_q.inst;
    end

    // EX/MEM register: only reset clears it; flush travels along as a qualifier
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign flush_mem      = ex_mem_q.flush;
    assign rd_mem         = ex_mem_q.rd;
    assign sig_op_mem     = ex_mem_q.sig_op;
    assign wdt_op_mem     = ex_mem_q.wdt_op;
    assign alu_result_mem = ex_mem_q.alu_result;
    assign rdata2_mem     = ex_mem_q.rdata2;
    assign imm_mem        = ex_mem_q.imm;
    assign pc_mem         = ex_mem_q.pc;
    assign inst_mem       = ex_mem_q.inst;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: ALU ops, branch/jal flush,
// load-use bypass and reset. Honours EXECUTE_STAGE_WORD_OPS_EN for W-op expectations.
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [4:0]        alu_op_id;
    logic [WDT_W-1:0]  wdt_op_id;
    logic [SIG_W-1:0]  sig_op_id;
    logic [XLEN-1:0]   imm_id, pc_id, rdata1_id, rdata2_id;
    logic [INST_W-1:0] inst_id;
    logic [RID_W-1:0]  rd_id;
    logic              flush_id, fwd1_id, fwd2_id;
    logic [XLEN-1:0]   load_data_mem;
    logic [XLEN-1:0]   alu_result_ex;
    logic [RID_W-1:0]  rd_ex;
    logic [SIG_W-1:0]  sig_op_ex;
    logic              flush_ex;
    logic              flush_mem;
    logic [RID_W-1:0]  rd_mem;
    logic [SIG_W-1:0]  sig_op_mem;
    logic [WDT_W-1:0]  wdt_op_mem;
    logic [XLEN-1:0]   alu_result_mem, rdata2_mem, imm_mem, pc_mem;
    logic [INST_W-1:0] inst_mem;

    localparam logic [SIG_W-1:0] S_WEN  = 11'b1 << SIG_REG_WEN;
    localparam logic [SIG_W-1:0] S_LOAD = 11'b1 << SIG_IS_LOAD;
    localparam logic [SIG_W-1:0] S_MEMW = 11'b1 << SIG_MEM_WEN;
    localparam logic [SIG_W-1:0] S_BR   = 11'b1 << SIG_IS_BRANCH;
    localparam logic [SIG_W-1:0] S_JAL  = 11'b1 << SIG_IS_JAL;
    localparam logic [SIG_W-1:0] S_IMM  = 11'b1 << SIG_NEED_IMM;

    localparam logic [XLEN-1:0] ALL1 = {XLEN{1'b1}};

    int n_tests = 0;
    int n_fail  = 0;

    execute_stage dut (
        .clk            (clk),
        .rst            (rst),
        .alu_op_id      (alu_op_id),
        .wdt_op_id      (wdt_op_id),
        .sig_op_id      (sig_op_id),
        .imm_id         (imm_id),
        .pc_id          (pc_id),
        .rdata1_id      (rdata1_id),
        .rdata2_id      (rdata2_id),
        .inst_id        (inst_id),
        .rd_id          (rd_id),
        .flush_id       (flush_id),
        .fwd1_id        (fwd1_id),
        .fwd2_id        (fwd2_id),
        .load_data_mem  (load_data_mem),
        .alu_result_ex  (alu_result_ex),
        .rd_ex          (rd_ex),
        .sig_op_ex      (sig_op_ex),
        .flush_ex       (flush_ex),
        .flush_mem      (flush_mem),
        .rd_mem         (rd_mem),
        .sig_op_mem     (sig_op_mem),
        .wdt_op_mem     (wdt_op_mem),
        .alu_result_mem (alu_result_mem),
        .rdata2_mem     (rdata2_mem),
        .imm_mem        (imm_mem),
        .pc_mem         (pc_mem),
        .inst_mem       (inst_mem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input alu_op_e op, input logic [SIG_W-1:0] sig,
                         input logic [XLEN-1:0] imm, input logic [XLEN-1:0] r1,
                         input logic [XLEN-1:0] r2, input logic [XLEN-1:0] pc,
                         input logic [RID_W-1:0] rd, input logic fl, input logic f1,
                         input logic f2);
        alu_op_id = op;
        wdt_op_id = WDT_D;
        sig_op_id = sig;
        imm_id    = imm;
        rdata1_id = r1;
        rdata2_id = r2;
        pc_id     = pc;
        inst_id   = 32'h0000_0013;
        rd_id     = rd;
        flush_id  = fl;
        fwd1_id   = f1;
        fwd2_id   = f2;
    endtask

    task automatic bubble();
        issue(ALU_NONE, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        inst_id = '0;
        wdt_op_id = '0;
    endtask

    // Issue one register-register op and check its combinational result in EX
    task automatic alu_vec(input string tag, input alu_op_e op, input logic [XLEN-1:0] r1,
                           input logic [XLEN-1:0] r2, input logic [XLEN-1:0] exp);
        issue(op, S_WEN, '0, r1, r2, '0, 5'd10, 1'b0, 1'b0, 1'b0);
        step();
        check(tag, alu_result_ex, exp);
    endtask

    initial begin
        rst = 1'b1;
        load_data_mem = '0;
        bubble();
        step();
        step();
        check("rst_alu_ex",   alu_result_ex, 64'h0);
        check("rst_flush_ex", 64'(flush_ex), 64'h0);
        check("rst_alu_mem",  alu_result_mem, 64'h0);
        rst = 1'b0;

        // 1. ADD 5+7 in EX, then in MEM
        issue(ALU_ADD, S_WEN, '0, 64'd5, 64'd7, 64'h100, 5'd3, 1'b0, 1'b0, 1'b0);
        step();
        check("add_ex",    alu_result_ex, 64'd12);
        check("add_rd_ex", 64'(rd_ex), 64'd3);
        bubble();
        step();
        check("add_mem",    alu_result_mem, 64'd12);
        check("add_rd_mem", 64'(rd_mem), 64'd3);
        check("add_pc_mem", pc_mem, 64'h100);
        check("add_ex_idle", alu_result_ex, 64'h0);

        // 2. Taken BEQ flushes and squashes the next ID instruction; BNE not taken
        issue(ALU_BEQ, S_BR, '0, 64'd3, 64'd3, 64'h200, '0, 1'b0, 1'b0, 1'b0);
        step();
        check("beq_flush", 64'(flush_ex), 64'h1);
        issue(ALU_ADD, S_WEN, '0, 64'd1, 64'd1, 64'h204, 5'd4, 1'b0, 1'b0, 1'b0);
        step();
        check("beq_squash_sig", 64'(sig_op_ex), 64'h0);
        check("beq_squash_rd",  64'(rd_ex), 64'h0);
        check("beq_flush_clr",  64'(flush_ex), 64'h0);
        check("beq_flush_mem",  64'(flush_mem), 64'h1);
        issue(ALU_BNE, S_BR, '0, 64'd3, 64'd3, 64'h208, '0, 1'b0, 1'b0, 1'b0);
        step();
        check("bne_noflush", 64'(flush_ex), 64'h0);
        check("bne_result",  alu_result_ex, 64'h0);

        // 3. jal: op1 = pc, flush from registered flush_id
        issue(ALU_ADD, S_WEN | S_JAL | S_IMM, 64'd8, 64'hDEAD, '0, 64'h8000_0010, 5'd1,
              1'b1, 1'b0, 1'b0);
        step();
        check("jal_result", alu_result_ex, 64'h8000_0018);
        check("jal_flush",  64'(flush_ex), 64'h1);
        issue(ALU_ADD, S_WEN, '0, 64'd1, 64'd1, 64'h8000_0014, 5'd7, 1'b0, 1'b0, 1'b0);
        step();
        check("jal_squash_rd",  64'(rd_ex), 64'h0);
        check("jal_squash_sig", 64'(sig_op_ex), 64'h0);
        check("jal_mem_result", alu_result_mem, 64'h8000_0018);
        check("jal_mem_flush",  64'(flush_mem), 64'h1);
        check("jal_mem_rd",     64'(rd_mem), 64'h1);

        // 4. Load-use bypass from MEM
        load_data_mem = 64'hAB;
        issue(ALU_ADD, S_WEN | S_LOAD | S_IMM, '0, 64'h2000, '0, 64'h300, 5'd5, 1'b0, 1'b0, 1'b0);
        step();
        issue(ALU_ADD, S_WEN, '0, 64'h10, 64'h22, 64'h304, 5'd6, 1'b0, 1'b0, 1'b1);
        step();
        check("byp_op2_load", alu_result_ex, 64'hBB);
        issue(ALU_ADD, S_WEN | S_LOAD | S_IMM, '0, 64'h2000, '0, 64'h308, 5'd5, 1'b0, 1'b0, 1'b0);
        step();
        issue(ALU_ADD, S_MEMW | S_IMM, 64'd8, 64'h1000, 64'h55, 64'h30C, '0, 1'b0, 1'b0, 1'b1);
        step();
        check("byp_sd_addr", alu_result_ex, 64'h1008);
        issue(ALU_ADD, S_WEN, '0, 64'h10, 64'h22, 64'h310, 5'd6, 1'b0, 1'b0, 1'b1);
        step();
        check("byp_no_load_op2", alu_result_ex, 64'h32);
        check("byp_sd_rdata2",   rdata2_mem, 64'hAB);
        bubble();
        step();
        check("byp_no_load_rdata2", rdata2_mem, 64'h22);
        load_data_mem = '0;

        // 5. ALU vectors incl. shift/compare edge cases
        alu_vec("sra",   ALU_SRA,  64'h8000_0000_0000_0000, 64'd1, 64'hC000_0000_0000_0000);
        alu_vec("srl",   ALU_SRL,  64'h8000_0000_0000_0000, 64'd1, 64'h4000_0000_0000_0000);
        alu_vec("sll",   ALU_SLL,  64'd1, 64'd67, 64'd8);
        alu_vec("sltu",  ALU_SLTU, ALL1, 64'd1, 64'd0);
        alu_vec("slt",   ALU_SLT,  ALL1, 64'd1, 64'd1);
        alu_vec("sub",   ALU_SUB,  64'd0, 64'd1, ALL1);
        alu_vec("addwr", ALU_ADD,  ALL1, 64'd1, 64'd0);
        alu_vec("and",   ALU_AND,  64'hF0F0, 64'hFF00, 64'hF000);
        alu_vec("or",    ALU_OR,   64'hF0F0, 64'hFF00, 64'hFFF0);
        alu_vec("xor",   ALU_XOR,  64'hF0F0, 64'hFF00, 64'h0FF0);
        alu_vec("blt",   ALU_BLT,  ALL1, 64'd1, 64'd1);
        alu_vec("bge",   ALU_BGE,  ALL1, 64'd1, 64'd0);
        alu_vec("bltu",  ALU_BLTU, ALL1, 64'd1, 64'd0);
        alu_vec("bgeu",  ALU_BGEU, ALL1, 64'd1, 64'd1);
        alu_vec("undef", alu_op_e'(5'd31), 64'd5, 64'd7, 64'd0);
        issue(ALU_LUI, S_WEN | S_IMM, 64'hFFFF_FFFF_ABCD_E000, 64'd9, 64'd9, '0, 5'd2,
              1'b0, 1'b0, 1'b0);
        step();
        check("lui", alu_result_ex, 64'hFFFF_FFFF_ABCD_E000);
`ifdef EXECUTE_STAGE_WORD_OPS_EN
        alu_vec("addw", ALU_ADDW, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000);
        alu_vec("sraw", ALU_SRAW, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000);
        alu_vec("subw", ALU_SUBW, 64'd0, 64'd1, ALL1);
`else
        alu_vec("addw_off", ALU_ADDW, 64'h7FFF_FFFF, 64'd1, 64'd0);
        alu_vec("sraw_off", ALU_SRAW, 64'h8000_0000, 64'd4, 64'd0);
`endif

        // 6. Reset mid-stream empties both registers in one edge
        issue(ALU_ADD, S_WEN, '0, 64'd2, 64'd3, 64'h40, 5'd9, 1'b0, 1'b0, 1'b0);
        step();
        issue(ALU_ADD, S_WEN, '0, 64'd4, 64'd4, 64'h44, 5'd11, 1'b1, 1'b0, 1'b0);
        step();
        check("pre_rst_rd_mem", 64'(rd_mem), 64'd9);
        check("pre_rst_flush",  64'(flush_ex), 64'h1);
        rst = 1'b1;
        issue(ALU_ADD, S_WEN, '0, 64'd6, 64'd6, 64'h48, 5'd12, 1'b1, 1'b0, 1'b0);
        step();
        check("rst_sig_ex",    64'(sig_op_ex), 64'h0);
        check("rst_rd_ex",     64'(rd_ex), 64'h0);
        check("rst_flush_ex2", 64'(flush_ex), 64'h0);
        check("rst_alu_mem2",  alu_result_mem, 64'h0);
        check("rst_rd_mem",    64'(rd_mem), 64'h0);
        check("rst_flush_mem", 64'(flush_mem), 64'h0);
        check("rst_pc_mem",    pc_mem, 64'h0);
        check("rst_sig_mem",   64'(sig_op_mem), 64'h0);
        rst = 1'b0;
        bubble();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
